keccak_state_sponge: RTL and testbench
======================================

Name: keccak_state_sponge

Overview:
- Parametrised Keccak sponge state holder. Builds on the fixed 1600-bit state-array mapping and adds width generalisation, streaming absorb and squeeze, and a permutation handshake.
- Absorbs message lanes into the rate portion of the state by XOR.
- Hands the full state to an external Keccak-f permutation core and loads the result back.
- Streams rate lanes out for squeeze. Sits between the padding/message front end and the permutation round core.

Parameters:
- LANE_W, 64, lane width w in bits. Legal values: 1, 2, 4, 8, 16, 32, 64. State width is 25*LANE_W.
- RATE_LANES, 17, number of rate lanes per block. Legal range 1..24. Default 17 suits SHA3-256; 21 suits SHAKE128.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous state wipe; dominates all other inputs.
- in_valid  in  1  absorb lane valid.
- in_ready  out  1  absorb lane accepted when in_valid && in_ready.
- in_lane  in  LANE_W  message lane; bit z maps to lane bit z.
- in_last  in  1  final lane of the current block (short block).
- squeeze_req  in  1  single-cycle request to output one rate block.
- perm_req  out  1  state is ready for permutation.
- perm_ack  in  1  single-cycle pulse: perm_state_in is valid.
- perm_state_in  in  25*LANE_W  permuted state, same layout as state_out.
- state_out  out  25*LANE_W  current state. Bit LANE_W*(x+5*y)+z = A[x][y][z].
- out_valid  out  1  squeeze lane valid.
- out_ready  in  1  squeeze lane consumer ready.
- out_lane  out  LANE_W  squeezed lane.
- busy  out  1  FSM not in ABSORB, or lane index != 0.

Behaviour:
- Lane index: idx, counting 0..RATE_LANES-1. Lane idx lives at x = idx mod 5, y = idx / 5.
- Reset (async, active-low):
  - state_out is all zero, idx = 0, FSM = ABSORB.
  - perm_req = 0, out_valid = 0, out_lane = 0, busy = 0.
  - in_ready is 1 whenever the FSM is ABSORB, including during reset.
- clear (synchronous, highest priority): zeroes the state, sets idx = 0, FSM = ABSORB, and abandons any pending permutation. perm_ack is ignored in the clear cycle.
- ABSORB state:
  - in_ready = 1.
  - On accept: lane[idx] <= lane[idx] ^ in_lane, and idx increments.
  - If idx == RATE_LANES-1 or in_last is set: idx <= 0 and FSM goes to PERMUTE on the same edge.
  - Capacity lanes (idx >= RATE_LANES) are never written by absorb.
- squeeze_req in ABSORB:
  - Honoured only when idx == 0 and no absorb handshake occurs in the same cycle; FSM then goes to SQUEEZE.
  - Otherwise it is dropped, not latched. Absorb wins over a simultaneous squeeze_req.
- PERMUTE state:
  - perm_req = 1 and state_out is held stable.
  - On perm_ack: the whole state <= perm_state_in, FSM goes to ABSORB, and perm_req drops in the next cycle. Minimum PERMUTE dwell is 1 cycle.
  - perm_ack outside PERMUTE is ignored.
- SQUEEZE state:
  - out_valid = 1 and out_lane = lane[idx] (combinational from the registered state and idx).
  - out_lane must be held stable while out_valid && !out_ready.
  - On a handshake, idx increments. On the handshake at idx == RATE_LANES-1: idx <= 0 and FSM goes to PERMUTE (automatic permutation for the next squeeze block).
  - in_ready = 0 and input lanes are not consumed.
- Latency:
  - Absorbed lane is visible on state_out 1 cycle after the handshake.
  - First squeeze lane is valid 1 cycle after squeeze_req is accepted.
- Reset asserted mid-operation returns everything to the reset values immediately. An in-flight permutation result is lost.
- No arithmetic other than XOR. idx width is clog2(RATE_LANES+1) bits.

Test Plan:
- Reset, then absorb in_lane=64'h1 with in_last=1 (LANE_W=64, RATE_LANES=17) -> state_out[0]=1, all other bits 0; perm_req=1 on the next cycle; busy=1.
- Absorb 17 lanes, lane k = k+1, with no in_last -> PERMUTE entered after the 17th handshake. Before ack, lane x=1,y=3 (idx 16) = 17. Capacity bits 1088..1599 = 0.
- In PERMUTE, drive perm_state_in = all 1s and pulse perm_ack -> state_out all 1s, FSM in ABSORB. Then absorb 64'hFFFF_FFFF_FFFF_FFFF -> lane 0 = 0.
- squeeze_req with state lanes = idx+100; hold out_ready=0 for 3 cycles, then 1 -> out_lane = 100 stable for the 3 stalled cycles, then 101..116. PERMUTE follows after lane 16.
- Simultaneous in_valid and squeeze_req at idx=0 -> lane absorbed, no SQUEEZE. squeeze_req at idx=3 -> ignored. perm_ack in ABSORB -> state unchanged.
- LANE_W=8, RATE_LANES=21: absorb 2 lanes, then assert clear -> state_out = 0, idx = 0. Also assert reset mid-SQUEEZE -> out_valid=0 and state_out=0 asynchronously.

Source files
------------

// File: rtl/keccak_state_sponge.sv
// -----------------------------------------------------------------------------
// keccak_state_sponge
//
// Sponge state holder for Keccak. Keeps the 25-lane state, XOR-absorbs message
// lanes into the rate portion, hands the whole state to an external Keccak-f
// permutation core (perm_req / perm_ack), and streams rate lanes back out for
// squeeze.
//
// State layout: bit LANE_W*(x+5*y)+z of state_out is A[x][y][z]. Lane index
// idx maps to x = idx mod 5, y = idx / 5. As a result, lane idx occupies bits
// [LANE_W*idx +: LANE_W], so no mod/div is needed to locate a lane.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   clear             synchronous state wipe, dominates every other input
//   in_valid/in_ready absorb lane handshake; in_lane is the lane data and
//                     in_last ends the current (short) block
//   squeeze_req       one-cycle request to stream out one rate block
//   perm_req          state is waiting for the permutation core
//   perm_ack          one-cycle pulse: perm_state_in holds the permuted state
//   perm_state_in     permuted state, same layout as state_out
//   state_out         current state
//   out_valid/out_ready/out_lane  squeeze lane handshake and data
//   busy              FSM is not in ABSORB, or a block is partially absorbed
// -----------------------------------------------------------------------------
module keccak_state_sponge #(
    parameter int LANE_W     = 64,
    parameter int RATE_LANES = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANE_W-1:0]      in_lane,
    input  logic                   in_last,
    input  logic                   squeeze_req,
    output logic                   perm_req,
    input  logic                   perm_ack,
    input  logic [25*LANE_W-1:0]   perm_state_in,
    output logic [25*LANE_W-1:0]   state_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANE_W-1:0]      out_lane,
    output logic                   busy
);

    localparam int STATE_W = 25 * LANE_W;
    localparam int IDX_W   = $clog2(RATE_LANES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

    typedef enum logic [1:0] {
        ST_ABSORB  = 2'd0,
        ST_PERMUTE = 2'd1,
        ST_SQUEEZE = 2'd2
    } fsm_t;

    fsm_t               fsm_r;
    logic [IDX_W-1:0]   idx_r;
    logic [STATE_W-1:0] state_r;

    logic [STATE_W-1:0] absorb_xor_s;
    logic [LANE_W-1:0]  lane_sel_s;

    // XOR mask that places in_lane over rate lane idx; capacity lanes stay zero
    always_comb begin
        absorb_xor_s = '0;
        for (int i = 0; i < RATE_LANES; i++) begin
            absorb_xor_s[i*LANE_W +: LANE_W] = (idx_r == IDX_W'(i)) ? in_lane : '0;
        end
    end

    // Rate lane selected by idx, built as an AND-OR mux from the registered state
    always_comb begin
        lane_sel_s = '0;
        for (int i = 0; i < RATE_LANES; i++) begin
            lane_sel_s = lane_sel_s |
                         ((idx_r == IDX_W'(i)) ? state_r[i*LANE_W +: LANE_W] : '0);
        end
    end

    // Sponge FSM: state register, lane index and mode sequencing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= '0;
            idx_r   <= '0;
            fsm_r   <= ST_ABSORB;
        end else if (clear) begin
            // Wipes everything; a pending permutation and any perm_ack are dropped
            state_r <= '0;
            idx_r   <= '0;
            fsm_r   <= ST_ABSORB;
        end else begin
            case (fsm_r)
                ST_ABSORB: begin
                    if (in_valid) begin
                        // Absorb wins over a simultaneous squeeze_req
                        state_r <= state_r ^ absorb_xor_s;
                        if ((idx_r == LAST_IDX) || in_last) begin
                            idx_r <= '0;
                            fsm_r <= ST_PERMUTE;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end else if (squeeze_req && (idx_r == '0)) begin
                        // Only a block boundary may start squeezing; else dropped
                        fsm_r <= ST_SQUEEZE;
                    end else begin
                        fsm_r <= ST_ABSORB;
                    end
                end
                ST_PERMUTE: begin
                    if (perm_ack) begin
                        state_r <= perm_state_in;
                        fsm_r   <= ST_ABSORB;
                    end else begin
                        fsm_r   <= ST_PERMUTE;
                    end
                end
                ST_SQUEEZE: begin
                    if (out_ready) begin
                        if (idx_r == LAST_IDX) begin
                            // Block fully read: permute so the next squeeze has fresh output
                            idx_r <= '0;
                            fsm_r <= ST_PERMUTE;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end else begin
                        fsm_r <= ST_SQUEEZE;
                    end
                end
                default: begin
                    idx_r <= '0;
                    fsm_r <= ST_ABSORB;
                end
            endcase
        end
    end

    // All outputs decode directly from registers, so they follow reset at once
    assign in_ready  = (fsm_r == ST_ABSORB);
    assign perm_req  = (fsm_r == ST_PERMUTE);
    assign out_valid = (fsm_r == ST_SQUEEZE);
    assign out_lane  = (fsm_r == ST_SQUEEZE) ? lane_sel_s : '0;
    assign busy      = (fsm_r != ST_ABSORB) || (idx_r != '0);
    assign state_out = state_r;

endmodule

// File: tb/tb_keccak_state_sponge.sv
// -----------------------------------------------------------------------------
// tb_keccak_state_sponge
//
// Directed bench for keccak_state_sponge. Instance a uses LANE_W=64 /
// RATE_LANES=17, instance b uses LANE_W=8 / RATE_LANES=21. Inputs change 1 time
// unit after the rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_keccak_state_sponge;

    logic clk;
    logic reset;

    // Instance a: 64-bit lanes, 17 rate lanes
    logic          a_clear, a_in_valid, a_in_ready, a_in_last, a_squeeze_req;
    logic          a_perm_req, a_perm_ack, a_out_valid, a_out_ready, a_busy;
    logic [63:0]   a_in_lane, a_out_lane;
    logic [1599:0] a_perm_state_in, a_state_out;

    // Instance b: 8-bit lanes, 21 rate lanes
    logic          b_clear, b_in_valid, b_in_ready, b_in_last, b_squeeze_req;
    logic          b_perm_req, b_perm_ack, b_out_valid, b_out_ready, b_busy;
    logic [7:0]    b_in_lane, b_out_lane;
    logic [199:0]  b_perm_state_in, b_state_out;

    logic [1599:0] pat_a;
    logic [199:0]  pat_b;

    int n_checks = 0;
    int n_pass   = 0;

    keccak_state_sponge #(.LANE_W(64), .RATE_LANES(17)) dut_a (
        .clk(clk), .reset(reset), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_lane(a_in_lane),
        .in_last(a_in_last), .squeeze_req(a_squeeze_req),
        .perm_req(a_perm_req), .perm_ack(a_perm_ack),
        .perm_state_in(a_perm_state_in), .state_out(a_state_out),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_lane(a_out_lane), .busy(a_busy)
    );

    keccak_state_sponge #(.LANE_W(8), .RATE_LANES(21)) dut_b (
        .clk(clk), .reset(reset), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_lane(b_in_lane),
        .in_last(b_in_last), .squeeze_req(b_squeeze_req),
        .perm_req(b_perm_req), .perm_ack(b_perm_ack),
        .perm_state_in(b_perm_state_in), .state_out(b_state_out),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_lane(b_out_lane), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_clear = 1'b0; a_in_valid = 1'b0; a_in_lane = '0; a_in_last = 1'b0;
        a_squeeze_req = 1'b0; a_perm_ack = 1'b0; a_perm_state_in = '0; a_out_ready = 1'b0;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_lane = '0; b_in_last = 1'b0;
        b_squeeze_req = 1'b0; b_perm_ack = 1'b0; b_perm_state_in = '0; b_out_ready = 1'b0;
        for (int i = 0; i < 25; i++) begin
            pat_a[i*64 +: 64] = 64'(i + 100);
            pat_b[i*8 +: 8]   = 8'(i + 1);
        end

        // Reset values
        #2 reset = 1'b0;
        #1;
        check("rst_in_ready", a_in_ready, 64'd1);
        check("rst_perm_req", a_perm_req, 64'd0);
        check("rst_out_valid", a_out_valid, 64'd0);
        check("rst_out_lane", a_out_lane, 64'd0);
        check("rst_busy", a_busy, 64'd0);
        check("rst_state", |a_state_out, 64'd0);
        step();
        reset = 1'b1;
        step();

        // Single short-block lane
        a_in_valid = 1'b1; a_in_lane = 64'h1; a_in_last = 1'b1;
        step();
        a_in_valid = 1'b0; a_in_last = 1'b0; a_in_lane = '0;
        check("short_lane0", a_state_out[63:0], 64'h1);
        check("short_rest0", |a_state_out[1599:64], 64'd0);
        check("short_perm_req", a_perm_req, 64'd1);
        check("short_busy", a_busy, 64'd1);
        check("short_in_ready", a_in_ready, 64'd0);
        a_perm_state_in = '0; a_perm_ack = 1'b1;
        step();
        a_perm_ack = 1'b0;
        check("ack0_state", |a_state_out, 64'd0);
        check("ack0_perm_req", a_perm_req, 64'd0);

        // Full 17-lane block, lane k = k+1
        for (int k = 0; k < 17; k++) begin
            a_in_valid = 1'b1; a_in_lane = 64'(k + 1);
            step();
            if (k == 15) check("full_no_perm_yet", a_perm_req, 64'd0);
        end
        a_in_valid = 1'b0; a_in_lane = '0;
        check("full_perm_req", a_perm_req, 64'd1);
        check("full_lane0", a_state_out[63:0], 64'd1);
        check("full_lane16", a_state_out[16*64 +: 64], 64'd17);
        check("full_capacity", |a_state_out[1599:1088], 64'd0);
        step();
        check("permute_hold", a_state_out[16*64 +: 64], 64'd17);
        check("permute_hold_req", a_perm_req, 64'd1);

        // Permutation result of all ones, then absorb all ones into lane 0
        a_perm_state_in = '1; a_perm_ack = 1'b1;
        step();
        a_perm_ack = 1'b0;
        check("ones_state", &a_state_out, 64'd1);
        check("ones_in_ready", a_in_ready, 64'd1);
        a_in_valid = 1'b1; a_in_lane = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        check("xor_lane0", a_state_out[63:0], 64'd0);
        check("xor_lane1", a_state_out[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
        check("xor_busy", a_busy, 64'd1);
        a_in_lane = '0;
        step();
        step();
        a_in_valid = 1'b0;

        // squeeze_req at idx 3 is dropped
        a_squeeze_req = 1'b1;
        step();
        a_squeeze_req = 1'b0;
        check("sq_mid_block_ov", a_out_valid, 64'd0);
        check("sq_mid_block_ir", a_in_ready, 64'd1);
        a_in_valid = 1'b1; a_in_last = 1'b1;
        step();
        a_in_valid = 1'b0; a_in_last = 1'b0;
        a_perm_state_in = pat_a; a_perm_ack = 1'b1;
        step();
        a_perm_ack = 1'b0;
        check("pat_lane0", a_state_out[63:0], 64'd100);

        // Absorb and squeeze_req together: absorb wins
        a_in_valid = 1'b1; a_in_lane = 64'h5; a_in_last = 1'b1; a_squeeze_req = 1'b1;
        step();
        a_in_valid = 1'b0; a_in_lane = '0; a_in_last = 1'b0; a_squeeze_req = 1'b0;
        check("race_out_valid", a_out_valid, 64'd0);
        check("race_perm_req", a_perm_req, 64'd1);
        check("race_lane0", a_state_out[63:0], 64'h61);
        a_perm_ack = 1'b1;
        step();
        a_perm_ack = 1'b0;

        // perm_ack outside PERMUTE is ignored
        a_perm_state_in = '0; a_perm_ack = 1'b1;
        step();
        a_perm_ack = 1'b0; a_perm_state_in = pat_a;
        check("stray_ack_lane0", a_state_out[63:0], 64'd100);
        check("stray_ack_lane24", a_state_out[24*64 +: 64], 64'd124);

        // Squeeze with three stalled cycles
        a_squeeze_req = 1'b1;
        step();
        a_squeeze_req = 1'b0;
        check("sq_out_valid", a_out_valid, 64'd1);
        check("sq_in_ready", a_in_ready, 64'd0);
        check("sq_stall0", a_out_lane, 64'd100);
        step();
        check("sq_stall1", a_out_lane, 64'd100);
        step();
        check("sq_stall2", a_out_lane, 64'd100);
        a_out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            check($sformatf("sq_lane%0d", k), a_out_lane, 64'(100 + k));
            step();
        end
        a_out_ready = 1'b0;
        check("sq_done_ov", a_out_valid, 64'd0);
        check("sq_done_perm", a_perm_req, 64'd1);

        // Instance b: clear after two absorbed lanes
        b_in_valid = 1'b1; b_in_lane = 8'hA5;
        step();
        b_in_lane = 8'h3C;
        step();
        check("b_two_lanes", b_state_out[15:0], 64'h3CA5);
        check("b_busy", b_busy, 64'd1);
        b_clear = 1'b1; b_in_lane = 8'hFF;
        step();
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_lane = '0;
        check("b_clear_state", |b_state_out, 64'd0);
        check("b_clear_busy", b_busy, 64'd0);
        check("b_clear_in_ready", b_in_ready, 64'd1);
        b_in_valid = 1'b1; b_in_lane = 8'h11; b_in_last = 1'b1;
        step();
        b_in_valid = 1'b0; b_in_lane = '0; b_in_last = 1'b0;
        check("b_short_lane0", b_state_out[7:0], 64'h11);
        check("b_perm_req", b_perm_req, 64'd1);
        b_perm_state_in = pat_b; b_perm_ack = 1'b1;
        step();
        b_perm_ack = 1'b0;
        check("b_pat_lane20", b_state_out[20*8 +: 8], 64'd21);
        b_squeeze_req = 1'b1;
        step();
        b_squeeze_req = 1'b0;
        check("b_sq_valid", b_out_valid, 64'd1);
        check("b_sq_lane0", b_out_lane, 64'd1);

        // Asynchronous reset in the middle of SQUEEZE
        #2 reset = 1'b0;
        #1;
        check("b_arst_out_valid", b_out_valid, 64'd0);
        check("b_arst_state", |b_state_out, 64'd0);
        check("b_arst_in_ready", b_in_ready, 64'd1);
        check("a_arst_state", |a_state_out, 64'd0);
        check("a_arst_perm_req", a_perm_req, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
